// File: rtl/watch_calendar_if.sv
// Bus between the 1 Hz tick source / set logic and the watch calendar counter.
// The master drives tick, set and alarm programming; the slave returns time and pulses.
interface watch_calendar_if;
    logic        clk1sec;
    logic        set_time;
    logic [47:0] bin_time;
    logic [2:0]  set_wday;
    logic        alarm_en;
    logic [23:0] alarm_time;
    logic [7:0]  year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
    logic [2:0]  weekday;
    logic        set_err;
    logic        alarm;
    logic        day_tick;

    modport master (
        output clk1sec, set_time, bin_time, set_wday, alarm_en, alarm_time,
        input  year, month, day, hour, minute, second, weekday, set_err, alarm, day_tick
    );

    modport slave (
        input  clk1sec, set_time, bin_time, set_wday, alarm_en, alarm_time,
        output year, month, day, hour, minute, second, weekday, set_err, alarm, day_tick
    );
endinterface

// File: rtl/watch_calendar.sv
// Seconds-to-year calendar counter with leap years, range-checked time load,
// hh:mm:ss alarm pulse and a midnight pulse. All outputs are registered.
module watch_calendar #(
    parameter int unsigned YEAR_BASE = 2000,
    parameter int unsigned YEAR_MAX  = 255,
    parameter int unsigned LEAP_EN   = 1,
    parameter int unsigned RST_WDAY  = 6
) (
    input logic              clk,
    input logic              rst,
    watch_calendar_if.slave  bus
);

    function automatic logic is_leap(input logic [7:0] yr);
        int unsigned y;
        y = YEAR_BASE + 32'(yr);
        return (LEAP_EN != 0) && (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic logic [7:0] max_day(input logic [7:0] mon, input logic [7:0] yr);
        case (mon)
            8'd2:                    return is_leap(yr) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
            default:                 return 8'd31;
        endcase
    endfunction

    logic [7:0] year_q, year_d, month_q, month_d, day_q, day_d;
    logic [7:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
    logic [2:0] weekday_q, weekday_d;
    logic       set_err_q, set_err_d, alarm_q, alarm_d, day_tick_q, day_tick_d;

    logic [7:0] b_year, b_month, b_day, b_hour, b_minute, b_second;
    logic       set_ok;

    assign {b_year, b_month, b_day, b_hour, b_minute, b_second} = bus.bin_time;

    always_comb begin
        set_ok = (b_month >= 8'd1) && (b_month <= 8'd12) &&
                 (b_day >= 8'd1) && (b_day <= max_day(b_month, b_year)) &&
                 (b_hour <= 8'd23) && (b_minute <= 8'd59) && (b_second <= 8'd59) &&
                 (32'(b_year) <= YEAR_MAX) && (bus.set_wday <= 3'd6);
    end

    always_comb begin
        year_d     = year_q;
        month_d    = month_q;
        day_d      = day_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        weekday_d  = weekday_q;
        set_err_d  = 1'b0;
        alarm_d    = 1'b0;
        day_tick_d = 1'b0;

        // A set request always swallows a coincident tick, even when rejected.
        if (bus.set_time) begin
            if (set_ok) begin
                year_d    = b_year;
                month_d   = b_month;
                day_d     = b_day;
                hour_d    = b_hour;
                minute_d  = b_minute;
                second_d  = b_second;
                weekday_d = bus.set_wday;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (bus.clk1sec) begin
            if (second_q < 8'd59) begin
                second_d = second_q + 8'd1;
            end else begin
                second_d = 8'd0;
                if (minute_q < 8'd59) begin
                    minute_d = minute_q + 8'd1;
                end else begin
                    minute_d = 8'd0;
                    if (hour_q < 8'd23) begin
                        hour_d = hour_q + 8'd1;
                    end else begin
                        hour_d     = 8'd0;
                        day_tick_d = 1'b1;
                        weekday_d  = (weekday_q == 3'd6) ? 3'd0 : weekday_q + 3'd1;
                        if (day_q < max_day(month_q, year_q)) begin
                            day_d = day_q + 8'd1;
                        end else begin
                            day_d = 8'd1;
                            if (month_q < 8'd12) begin
                                month_d = month_q + 8'd1;
                            end else begin
                                month_d = 8'd1;
                                year_d  = (year_q == 8'(YEAR_MAX)) ? 8'd0 : year_q + 8'd1;
                            end
                        end
                    end
                end
            end
            alarm_d = bus.alarm_en && ({hour_d, minute_d, second_d} == bus.alarm_time);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            year_q     <= 8'd0;
            month_q    <= 8'd1;
            day_q      <= 8'd1;
            hour_q     <= 8'd0;
            minute_q   <= 8'd0;
            second_q   <= 8'd0;
            weekday_q  <= 3'(RST_WDAY);
            set_err_q  <= 1'b0;
            alarm_q    <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            year_q     <= year_d;
            month_q    <= month_d;
            day_q      <= day_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            weekday_q  <= weekday_d;
            set_err_q  <= set_err_d;
            alarm_q    <= alarm_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign bus.year     = year_q;
    assign bus.month    = month_q;
    assign bus.day      = day_q;
    assign bus.hour     = hour_q;
    assign bus.minute   = minute_q;
    assign bus.second   = second_q;
    assign bus.weekday  = weekday_q;
    assign bus.set_err  = set_err_q;
    assign bus.alarm    = alarm_q;
    assign bus.day_tick = day_tick_q;

endmodule

// File: tb/tb_watch_calendar.sv
// Directed bench for watch_calendar: the driver queues hand-computed expected states,
// a negedge monitor pops and compares them against the registered outputs.
module tb_watch_calendar;

    typedef struct {
        string       name;
        logic [53:0] v;
    } exp_t;

    logic clk;
    logic rst;
    watch_calendar_if bus ();

    watch_calendar #(
        .YEAR_BASE (2000),
        .YEAR_MAX  (255),
        .LEAP_EN   (1),
        .RST_WDAY  (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic string fmt(input logic [53:0] v);
        return $sformatf("%0d-%0d-%0d %0d:%0d:%0d wd=%0d err=%0b alm=%0b dt=%0b",
                         v[53:46], v[45:38], v[37:30], v[29:22], v[21:14], v[13:6],
                         v[5:3], v[2], v[1], v[0]);
    endfunction

    always @(negedge clk) begin
        logic [53:0] act;
        exp_t        e;
        act = {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second,
               bus.weekday, bus.set_err, bus.alarm, bus.day_tick};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %s, required %s", e.name, fmt(act), fmt(e.v));
            end
        end
    end

    task automatic expect_st(input string name, input int y, input int mo, input int d,
                             input int h, input int mi, input int s, input int wd,
                             input bit err, input bit alm, input bit dt);
        exp_t e;
        e.name = name;
        e.v    = {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s), 3'(wd), err, alm, dt};
        sb.push_back(e);
    endtask

    // One clock with the given strobes; returns 1 ns after the sampling edge.
    task automatic op(input bit tick, input bit set, input int y, input int mo, input int d,
                      input int h, input int mi, input int s, input int wd);
        @(negedge clk);
        bus.clk1sec  = tick;
        bus.set_time = set;
        bus.bin_time = {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
        bus.set_wday = 3'(wd);
        @(posedge clk);
        #1;
        bus.clk1sec  = 1'b0;
        bus.set_time = 1'b0;
    endtask

    task automatic tick();
        op(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set(input int y, input int mo, input int d, input int h, input int mi,
                       input int s, input int wd);
        op(1'b0, 1'b1, y, mo, d, h, mi, s, wd);
    endtask

    initial begin
        rst            = 1'b0;
        bus.clk1sec    = 1'b0;
        bus.set_time   = 1'b0;
        bus.bin_time   = '0;
        bus.set_wday   = '0;
        bus.alarm_en   = 1'b0;
        bus.alarm_time = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_st("reset", 0, 1, 1, 0, 0, 0, 6, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        tick(); expect_st("tick1", 0, 1, 1, 0, 0, 1, 6, 0, 0, 0);
        tick();
        tick(); expect_st("tick3", 0, 1, 1, 0, 0, 3, 6, 0, 0, 0);
        idle(); expect_st("hold", 0, 1, 1, 0, 0, 3, 6, 0, 0, 0);

        set(24, 2, 28, 23, 59, 59, 3); expect_st("set2024", 24, 2, 28, 23, 59, 59, 3, 0, 0, 0);
        tick(); expect_st("leap2024", 24, 2, 29, 0, 0, 0, 4, 0, 0, 1);
        idle(); expect_st("dt_clear", 24, 2, 29, 0, 0, 0, 4, 0, 0, 0);

        set(23, 2, 28, 23, 59, 59, 1);
        tick(); expect_st("nonleap2023", 23, 3, 1, 0, 0, 0, 2, 0, 0, 1);
        set(100, 2, 28, 23, 59, 59, 5);
        tick(); expect_st("nonleap2100", 100, 3, 1, 0, 0, 0, 6, 0, 0, 1);
        set(0, 2, 28, 23, 59, 59, 1);
        tick(); expect_st("leap2000", 0, 2, 29, 0, 0, 0, 2, 0, 0, 1);

        set(255, 12, 31, 23, 59, 59, 6);
        tick(); expect_st("year_wrap", 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);

        set(5, 13, 1, 0, 0, 0, 1);  expect_st("bad_month", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        set(5, 4, 31, 0, 0, 0, 1);  expect_st("bad_apr31", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        set(5, 1, 1, 0, 0, 60, 1);  expect_st("bad_sec", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        set(23, 2, 29, 0, 0, 0, 1); expect_st("bad_feb29", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        set(5, 1, 0, 0, 0, 0, 1);   expect_st("bad_day0", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        set(5, 1, 1, 0, 0, 0, 7);   expect_st("bad_wday", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        op(1'b1, 1'b1, 5, 1, 1, 24, 0, 0, 1);
        expect_st("bad_set_drops_tick", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        idle(); expect_st("err_clear", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        op(1'b1, 1'b1, 10, 6, 15, 12, 30, 45, 2);
        expect_st("set_beats_tick", 10, 6, 15, 12, 30, 45, 2, 0, 0, 0);

        bus.alarm_time = {8'd0, 8'd0, 8'd5};
        bus.alarm_en   = 1'b1;
        set(1, 1, 1, 23, 59, 59, 0);
        tick(); expect_st("midnight", 1, 1, 2, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            tick(); expect_st($sformatf("pre_alarm%0d", i), 1, 1, 2, 0, 0, i, 1, 0, 0, 0);
        end
        tick(); expect_st("alarm", 1, 1, 2, 0, 0, 5, 1, 0, 1, 0);
        idle(); expect_st("alarm_clear", 1, 1, 2, 0, 0, 5, 1, 0, 0, 0);

        bus.alarm_en = 1'b0;
        set(1, 1, 2, 0, 0, 4, 1);
        tick(); expect_st("alarm_disabled", 1, 1, 2, 0, 0, 5, 1, 0, 0, 0);
        bus.alarm_en = 1'b1;
        set(1, 1, 2, 0, 0, 5, 1); expect_st("alarm_not_on_set", 1, 1, 2, 0, 0, 5, 1, 0, 0, 0);

        set(7, 7, 7, 7, 7, 7, 3);
        tick(); expect_st("pre_reset", 7, 7, 7, 7, 7, 8, 3, 0, 0, 0);
        @(posedge clk);
        #3;
        rst         = 1'b0;
        bus.clk1sec = 1'b1;
        #1;
        expect_st("async_reset", 0, 1, 1, 0, 0, 0, 6, 0, 0, 0);
        @(posedge clk);
        #1;
        expect_st("reset_over_tick", 0, 1, 1, 0, 0, 0, 6, 0, 0, 0);
        @(negedge clk);
        rst         = 1'b1;
        bus.clk1sec = 1'b0;
        tick(); expect_st("after_reset", 0, 1, 1, 0, 0, 1, 6, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
